if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the single-issue MIPS core, directly upstream of the control unit `UC`. It:
- owns the program counter;
- runs a request/ready handshake to instruction memory;
- holds the fetched word in an instruction register whose `[31:26]`/`[5:0]` fields drive `UC` opcode/funct.
- consumes `UC`'s `jump_flag`, `branch_flag`, `jal_flag` and `jr_flag` to compute the next PC.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  holds the block in FETCH; no new memory request is issued.
- `imem_req`  out  1  one-cycle fetch request.
- `imem_addr`  out  32  word address of the request; equals `pc`.
- `imem_ready`  in  1  `imem_data` valid this cycle; sampled only in WAIT.
- `imem_data`  in  32  returned instruction word.
- `jump_flag`, `branch_flag`, `jal_flag`, `jr_flag`  in  1 each  from `UC`, decoded from `ir`.
- `branch_cond`  in  1  datapath comparison result (beq equal / bne not-equal already resolved).
- `rs_value`  in  32  register-file rs read, the jr target.
- `ir`  out  32  instruction register.
- `ir_valid`  out  1  high exactly in DECODE; `ir` and the `UC` outputs are meaningful this cycle.
- `link_addr`  out  32  PC of the instruction in `ir` + 4, written to $31 by jal.
- `pc`  out  32  current program counter.

## Operation
- States: FETCH, WAIT, DECODE.
- FETCH:
  - `imem_req = ~stall`, `imem_addr = pc`.
  - `stall=1` → stay in FETCH.
  - `stall=0` → WAIT.
- WAIT:
  - `imem_req = 0`.
  - `imem_ready=0` → stay.
  - `imem_ready=1` → `ir <= imem_data`, `link_addr <= pc + 4`, go to DECODE.
- DECODE:
  - `ir_valid = 1`.
  - `pc <= next_pc`, then go to FETCH.
  - `stall` is ignored here.
- `next_pc` priority (first match wins):
  1. `jr_flag` → `rs_value`.
  2. `jump_flag | jal_flag` → `{link_addr[31:28], ir[25:0], 2'b00}`.
  3. `branch_flag & branch_cond` → `link_addr + {{14{ir[15]}}, ir[15:0], 2'b00}`.
  4. Otherwise → `link_addr`.
- Arithmetic: all 32-bit modulo 2^32; PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- No branch delay slot: the redirect takes effect on the very next fetch.
- `imem_ready` outside WAIT is ignored, including a late response after reset.
- `rs_value[1:0]` is used unmodified; misalignment is not checked.

## Timing
- Reset values: `pc = RESET_VECTOR`, state FETCH, `ir = 0`, `link_addr = 0`, `ir_valid = 0`.
- `imem_req` is forced to 0 in any cycle where `reset = 1`.
- Minimum throughput is 3 cycles per instruction:
  - `imem_req` at cycle t;
  - ready at t+1;
  - `ir_valid` at t+2;
  - next `imem_req` at t+3.
- Each extra cycle of `imem_ready=0` adds one cycle.
- `ir_valid` is a single-cycle pulse per fetched instruction.
- The `UC` flags, `branch_cond` and `rs_value` are sampled only in that cycle.
- `ir` and `link_addr` hold their values until the next capture.
- `pc` changes only on the DECODE→FETCH edge or on reset.
- Reset mid-WAIT: pending response is abandoned, state returns to FETCH, `pc = RESET_VECTOR`.
- Simultaneous `stall` and `reset`: reset wins.
- Simultaneous `jr_flag` and `jal_flag` (illegal decode): jr target wins.

## Structure
- Shared package:
  - state encoding (FETCH=2'd0, WAIT=2'd1, DECODE=2'd2);
  - `RESET_VECTOR` default;
  - instruction field positions (opcode 31:26, target 25:0, imm 15:0).
- One combinational sub-module, `next_pc_sel`. Inputs: `link_addr`, `ir`, `rs_value`, the four flags and `branch_cond`. Output: `next_pc`.
- The FSM, PC register and IR stay in `if_stage`.

## Test plan
- Reset then sequential fetch:
  - stimulus: `RESET_VECTOR = 0`; memory returns 32'h2008_0005 (addi) at addr 0 with ready one cycle after each request.
  - required: `imem_req` at cycles 1, 4, 7; `imem_addr` = 0, 4, 8; `ir_valid` at cycles 3, 6.
- Memory wait states:
  - stimulus: `imem_ready` delayed 3 cycles.
  - required: block stays in WAIT; `ir_valid` rises exactly one cycle after ready; `pc` unchanged until DECODE.
- Taken beq:
  - stimulus: `ir` = 32'h1000_FFFF at `pc` 32'h40; `branch_flag = 1`, `branch_cond = 1`.
  - required: next `imem_addr` = 32'h40.
- Not-taken beq:
  - stimulus: same as taken beq but `branch_cond = 0`.
  - required: next `imem_addr` = 32'h44.
- jal and jr:
  - stimulus: jal 32'h0C00_0010 at 32'h100; then jr with `rs_value` = 32'h104.
  - required: `link_addr` = 32'h104 and next fetch 32'h40; after the jr, next fetch 32'h104.
- Stall and reset mid-transaction:
  - stall held 4 cycles in FETCH → no `imem_req`, `pc` held.
  - reset asserted in WAIT, then `imem_ready` pulses after reset → ignored; first request after reset is to `RESET_VECTOR`.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset vector
// default and MIPS instruction field positions.
package if_stage_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StWait   = 2'd1,
    StDecode = 2'd2
  } if_state_e;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jr, then j/jal, then taken branch, else fall-through.
module next_pc_sel
  import if_stage_pkg::*;
(
  input  logic [31:0] link_addr,
  input  logic [31:0] ir,
  input  logic [31:0] rs_value,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        jal_flag,
  input  logic        jr_flag,
  input  logic        branch_cond,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        unused_opcode;

  // Opcode is decoded upstream; only target and immediate fields matter here.
  assign unused_opcode = ^ir[OpcodeMsb:OpcodeLsb];

  assign jump_target   = {link_addr[31:28], ir[TargetMsb:TargetLsb], 2'b00};
  assign branch_target = link_addr + {{14{ir[ImmMsb]}}, ir[ImmMsb:ImmLsb], 2'b00};

  always_comb begin
    next_pc = link_addr;
    if (jr_flag) begin
      next_pc = rs_value;
    end else if (jump_flag | jal_flag) begin
      next_pc = jump_target;
    end else if (branch_flag & branch_cond) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// holds the fetched word for the control unit.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DefaultResetVector
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        jal_flag,
  input  logic        jr_flag,
  input  logic        branch_cond,
  input  logic [31:0] rs_value,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] link_addr,
  output logic [31:0] pc
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] link_q;
  logic [31:0] next_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (!stall) state_d = StWait;
      StWait:   if (imem_ready) state_d = StDecode;
      StDecode: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_valid = 1'b0;
    unique case (state_q)
      StFetch:  imem_req = ~stall & ~reset;
      StDecode: ir_valid = 1'b1;
      default:  ;
    endcase
  end

  // A response arriving outside WAIT never touches ir/link_addr.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      ir_q   <= '0;
      link_q <= '0;
    end else begin
      if (state_q == StWait && imem_ready) begin
        ir_q   <= imem_data;
        link_q <= pc_q + 32'd4;
      end
      if (state_q == StDecode) begin
        pc_q <= next_pc;
      end
    end
  end

  next_pc_sel u_next_pc_sel (
    .link_addr   (link_q),
    .ir          (ir_q),
    .rs_value    (rs_value),
    .jump_flag   (jump_flag),
    .branch_flag (branch_flag),
    .jal_flag    (jal_flag),
    .jr_flag     (jr_flag),
    .branch_cond (branch_cond),
    .next_pc     (next_pc)
  );

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign link_addr = link_q;

endmodule
